// File: rtl/i2c_phase_gen.sv
// rtl/i2c_phase_gen.sv - I2C SCL quarter-phase generator with drive/sample/bit ticks
// Optional clock stretching on scl_in is enabled by defining I2C_STRETCH_EN.
module i2c_phase_gen #(
  parameter int CLK_HZ = 100_000_000,
  parameter int DIV_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_cfg,
  input  logic             scl_in,
  output logic             scl_o,
  output logic [1:0]       phase,
  output logic             drive_tick,
  output logic             sample_tick,
  output logic             bit_tick,
  output logic             busy,
  output logic             stretching
);

  localparam logic [DIV_W-1:0] Q_100K = DIV_W'(CLK_HZ / (4 * 100_000));
  localparam logic [DIV_W-1:0] Q_400K = DIV_W'(CLK_HZ / (4 * 400_000));
  localparam logic [DIV_W-1:0] Q_1M   = DIV_W'(CLK_HZ / (4 * 1_000_000));

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] count, count_n;
  logic [DIV_W-1:0] q_cur, q_cur_n, q_sel;
  logic [1:0]       phase_n;
  logic             scl_n, drive_n, sample_n, bit_n, busy_n, stretch_n;
  logic             hold;

  always_comb begin
    case (mode)
      2'd0:    q_sel = Q_100K;
      2'd1:    q_sel = Q_400K;
      2'd2:    q_sel = Q_1M;
      default: q_sel = (div_cfg < DIV_W'(2)) ? DIV_W'(2) : div_cfg;
    endcase
  end

`ifdef I2C_STRETCH_EN
  logic [1:0] scl_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) scl_sync <= 2'b11;
    else       scl_sync <= {scl_sync[0], scl_in};
  end

  // A slave may only stretch while we have released SCL (phase 2).
  assign hold = (phase == 2'd2) && !scl_sync[1];
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign hold = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    count_n   = count;
    phase_n   = phase;
    q_cur_n   = q_cur;
    drive_n   = 1'b0;
    sample_n  = 1'b0;
    bit_n     = 1'b0;
    stretch_n = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_n = RUN;
          count_n = '0;
          phase_n = 2'd0;
          q_cur_n = q_sel;
          drive_n = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_n = IDLE;
          count_n = '0;
          phase_n = 2'd0;
        end else if (hold) begin
          stretch_n = 1'b1;
        end else if (count == q_cur - DIV_W'(1)) begin
          count_n = '0;
          phase_n = phase + 2'd1;
          sample_n = (phase == 2'd2);
          if (phase == 2'd3) begin
            // Bit boundary: the only point besides start-up where a new speed takes effect.
            drive_n = 1'b1;
            bit_n   = 1'b1;
            q_cur_n = q_sel;
          end
        end else begin
          count_n = count + DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    scl_n  = (state_n == IDLE) || phase_n[1];
    busy_n = (state_n == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      phase       <= 2'd0;
      q_cur       <= Q_100K;
      scl_o       <= 1'b1;
      drive_tick  <= 1'b0;
      sample_tick <= 1'b0;
      bit_tick    <= 1'b0;
      busy        <= 1'b0;
      stretching  <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      phase       <= phase_n;
      q_cur       <= q_cur_n;
      scl_o       <= scl_n;
      drive_tick  <= drive_n;
      sample_tick <= sample_n;
      bit_tick    <= bit_n;
      busy        <= busy_n;
      stretching  <= stretch_n;
    end
  end

endmodule

// File: tb/tb_i2c_phase_gen.sv
// tb/tb_i2c_phase_gen.sv - self-checking bench for i2c_phase_gen
module tb_i2c_phase_gen;
  logic        clk = 1'b0;
  logic        reset, en, scl_in;
  logic [1:0]  mode;
  logic [15:0] div_cfg;
  logic        scl_o, drive_tick, sample_tick, bit_tick, busy, stretching;
  logic [1:0]  phase;
  logic        line_mode = 1'b0, slave_low = 1'b0, chk_en = 1'b1;
  int          errors = 0, checks = 0;

  localparam logic [7:0] IDLE_V = 8'b0010_0000;

  i2c_phase_gen dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .div_cfg(div_cfg),
    .scl_in(scl_in), .scl_o(scl_o), .phase(phase), .drive_tick(drive_tick),
    .sample_tick(sample_tick), .bit_tick(bit_tick), .busy(busy), .stretching(stretching)
  );

  always #5 clk = ~clk;

  // Wired-AND SCL line when a slave is modelled, otherwise a quiet pulled-up line.
  assign scl_in = line_mode ? (scl_o & ~slave_low) : 1'b1;

  function automatic logic [7:0] outv();
    return {phase, scl_o, drive_tick, sample_tick, bit_tick, busy, stretching};
  endfunction

  function automatic int qof(input logic [1:0] m, input logic [15:0] d);
    case (m)
      2'd0:    return 250;
      2'd1:    return 62;
      2'd2:    return 25;
      default: return (d < 16'd2) ? 2 : int'(d);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return drive_tick;
      1:       return sample_tick;
      2:       return bit_tick;
      3:       return phase == 2'd1;
      4:       return phase == 2'd2;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cond(sel) && n < max);
    if (!cond(sel)) begin
      checks++;
      errors++;
      $display("FAIL timeout sel=%0d: waited %0d cycles", sel, n);
    end
  endtask

  // Model: position p within the current bit of quarter length q decides every output.
  initial begin
    bit         m_run = 1'b0, m_first = 1'b0;
    int         m_p = 0, m_q = 250, ph;
    logic       s_rst, s_en;
    logic [1:0] s_mode;
    logic [15:0] s_div;
    logic [7:0] exp_v;
    forever begin
      @(posedge clk);
      s_rst = reset; s_en = en; s_mode = mode; s_div = div_cfg;
      #1;
      if (s_rst) m_run = 1'b0;
      else if (!m_run) begin
        if (s_en) begin
          m_run = 1'b1; m_p = 0; m_first = 1'b1; m_q = qof(s_mode, s_div);
        end
      end else if (!s_en) m_run = 1'b0;
      else begin
        m_p++;
        if (m_p == 4 * m_q) begin
          m_p = 0; m_first = 1'b0; m_q = qof(s_mode, s_div);
        end
      end
      if (m_run) begin
        ph = m_p / m_q;
        exp_v = {2'(ph), ph >= 2, m_p == 0, m_p == 3 * m_q, m_p == 0 && !m_first, 1'b1, 1'b0};
      end else exp_v = IDLE_V;
      if (chk_en) check("cycle_outputs", int'(outv()), int'(exp_v));
    end
  end

  initial begin
    int n, tot, stc;
    reset = 1'b1; en = 1'b0; mode = 2'd0; div_cfg = 16'd0;
    repeat (3) @(negedge clk);
    check("reset_state", int'(outv()), int'(IDLE_V));
    reset = 1'b0; mode = 2'd1; en = 1'b1;

    wait_for(0, 10, n);   check("first_drive_latency", n, 1);
    wait_for(3, 300, n);  check("q400_phase_len", n, 62);
    wait_for(2, 300, n);  check("q400_first_bit_rest", n, 186);
    wait_for(2, 300, n);  check("q400_bit_period", n, 248);

    mode = 2'd0;
    wait_for(2, 300, n);  check("mode_change_next_bit", n, 248);
    wait_for(4, 1200, n); tot = n;
    mode = 2'd2;
    wait_for(2, 1200, n); check("q100_bit_kept", tot + n, 1000);
    wait_for(2, 300, n);  check("q1m_bit_period", n, 100);

    mode = 2'd3; div_cfg = 16'd0;
    wait_for(2, 300, n);  check("custom_prev_bit", n, 100);
    wait_for(2, 50, n);   check("div0_clamped", n, 8);
    div_cfg = 16'd1;
    wait_for(2, 50, n);   check("div0_second", n, 8);
    wait_for(2, 50, n);   check("div1_clamped", n, 8);
    div_cfg = 16'd7;
    wait_for(2, 50, n);   check("div7_prev_bit", n, 8);
    wait_for(2, 100, n);  check("div7_period", n, 28);

    mode = 2'd1;
    wait_for(2, 100, n);  check("back_to_q400", n, 28);
    wait_for(3, 300, n);  check("phase1_entry", n, 62);
    repeat (10) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en_drop_idle", int'(outv()), int'(IDLE_V));
    repeat (5) @(negedge clk);
    en = 1'b1;
    wait_for(0, 10, n);   check("restart_latency", n, 1);
    check("restart_no_bit_tick", int'(bit_tick), 0);
    wait_for(2, 300, n);  check("restart_bit_period", n, 248);

    wait_for(4, 300, n);  check("phase2_entry", n, 124);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", int'(outv()), int'(IDLE_V));
    @(negedge clk);
    reset = 1'b0; en = 1'b0;
    repeat (4) @(negedge clk);
    check("post_reset_idle", int'(busy), 0);
    en = 1'b1;
    wait_for(0, 10, n);   check("post_reset_latency", n, 1);
    wait_for(2, 300, n);  check("post_reset_bit", n, 248);

    chk_en = 1'b0; line_mode = 1'b1;
    wait_for(4, 300, n);  tot = n;
    slave_low = 1'b1;
    n = 0; stc = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 100) slave_low = 1'b0;
      if (stretching) stc++;
    end while (!bit_tick && n < 1000);
`ifdef I2C_STRETCH_EN
    check("stretch_period", tot + n, 350);
    check("stretch_cycles", stc, 102);
`else
    check("stretch_period", tot + n, 248);
    check("stretch_cycles", stc, 0);
`endif

    reset = 1'b1; slave_low = 1'b0; line_mode = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    check("final_reset", int'(outv()), int'(IDLE_V));
    reset = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_phase_gen.md
I2C_PHASE_GEN -- requirements
Module: i2c_phase_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter DIV_W, default 16, meaning width of the quarter-period counter and of div_cfg.
REQ-003 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  run request; 1 runs the SCL phase sequence, 0 returns the block to idle.
REQ-006 SHALL have port mode  input  2  bus speed: 0 = 100 kHz, 1 = 400 kHz, 2 = 1 MHz, 3 = custom.
REQ-007 SHALL have port div_cfg  input  DIV_W  custom quarter-period in clk cycles, used when mode = 3.
REQ-008 SHALL have port scl_in  input  1  sensed SCL line level, asynchronous to clk.
REQ-009 SHALL have port scl_o  output  1  SCL drive: 0 = pull low, 1 = release.
REQ-010 SHALL have port phase  output  2  current quarter-phase, 0..3.
REQ-011 SHALL have port drive_tick  output  1  one-cycle pulse marking when SDA may change.
REQ-012 SHALL have port sample_tick  output  1  one-cycle pulse marking when SDA is sampled.
REQ-013 SHALL have port bit_tick  output  1  one-cycle pulse marking a completed bit period.
REQ-014 SHALL have port busy  output  1  1 while the phase sequence runs.
REQ-015 SHALL have port stretching  output  1  1 while a slave holds SCL low during phase 2.

Function
REQ-016 SHALL compute the quarter-period Q at elaboration as CLK_HZ/(4*f), truncated: 250 for 100 kHz, 62 for 400 kHz and 25 for 1 MHz at the default CLK_HZ.
REQ-017 SHALL use Q = div_cfg for mode 3, with values below 2 clamped to 2.
REQ-018 SHALL latch mode and div_cfg only on idle-to-run entry and on each bit_tick cycle; changes at any other time SHALL NOT affect the bit in progress.
REQ-019 SHALL have states IDLE and RUN; in RUN the counter SHALL count 0..Q-1, then advance phase 0->1->2->3->0 with the counter cleared.
REQ-020 SHALL drive scl_o = 0 in phases 0 and 1, scl_o = 1 in phases 2 and 3, and scl_o = 1 in IDLE.
REQ-021 SHALL make the IDLE-to-RUN transition in the cycle after en is first sampled as 1, entering phase 0 with count 0.
REQ-022 SHALL assert drive_tick for exactly the first cycle of every phase 0.
REQ-023 SHALL assert sample_tick for exactly the first cycle of every phase 3.
REQ-024 SHALL assert bit_tick for the first cycle of a phase 0 that follows phase 3, and SHALL NOT assert it on the initial entry from IDLE.
REQ-025 SHALL make the unstretched bit period exactly 4*Q clk cycles.
REQ-026 SHALL, when en is sampled 0 in RUN, enter IDLE on the next cycle in any phase: counter 0, phase 0, scl_o = 1, all ticks 0, busy = 0.
REQ-027 SHALL, when en is 1 in the same cycle as a phase wrap, complete the wrap normally.
REQ-028 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-029 SHALL, on reset asserted, immediately set state IDLE, count 0, phase 0, scl_o = 1, drive_tick, sample_tick, bit_tick, busy and stretching = 0, latched Q = the 100 kHz value, and synchronizer flops = 1.
REQ-030 SHALL, when reset is asserted mid-bit, abandon the bit with no ticks, and SHALL require a new en sample after reset release before restarting.

Configuration
REQ-031 SHALL implement clock stretching, under macro I2C_STRETCH_EN, as follows: scl_in passes a 2-flop synchronizer; in phase 2, while the synchronized scl_in = 0, the counter holds and stretching = 1; counting resumes on the cycle the synchronized level reads 1.
REQ-032 SHALL, without I2C_STRETCH_EN, omit the synchronizer, ignore scl_in, tie stretching to 0, and never hold phase 2.

Verification
REQ-033 SHALL cover: reset, en = 1, mode = 1 -> first drive_tick 1 cycle after en, phase edges every 62 cycles, bit_tick every 248 cycles.
REQ-034 SHALL cover: mode changed 0->2 mid-bit -> current bit keeps 1000 cycles; the next bit is 100 cycles.
REQ-035 SHALL cover: mode = 3, div_cfg = 0, then div_cfg = 1 -> Q = 2, bit_tick every 8 cycles.
REQ-036 SHALL cover: en dropped in phase 1 at count 10 -> next cycle scl_o = 1, busy = 0, no bit_tick; re-enabling restarts at phase 0 without bit_tick.
REQ-037 SHALL cover, with I2C_STRETCH_EN: scl_in held 0 for 100 cycles from phase 2 start, mode 1 -> stretching high about 102 cycles, bit period 248 plus the hold length; without the macro -> period 248.
REQ-038 SHALL cover: reset pulsed during phase 2 -> all outputs at reset values within the same cycle, no ticks until en is resampled.
